// File: rtl/hft_pkg.sv
// Constants and types shared by the graph loader and the Bellman/cycle-detect container.
package hft_pkg;
    localparam int NODES        = 16;
    localparam int WEIGHT_WIDTH = 16;

    localparam int N_NODES  = NODES;
    localparam int IDX_W    = $clog2(NODES);
    localparam int WEIGHT_W = WEIGHT_WIDTH;
    localparam int ADDR_W   = 2*IDX_W + 1;

    typedef logic signed [WEIGHT_W-1:0] weight_t;
    typedef weight_t [N_NODES-1:0][N_NODES-1:0] adjmat_t;
    typedef logic [IDX_W-1:0] idx_t;

    // Largest positive weight stands for "no edge".
    localparam weight_t INF = {1'b0, {(WEIGHT_W-1){1'b1}}};

    localparam logic [1:0] CTRL_OFF   = 2'd0;
    localparam logic [1:0] SRC_OFF    = 2'd1;
    localparam logic [1:0] STATUS_OFF = 2'd2;

    localparam int CTRL_START   = 0;
    localparam int CTRL_CLEAR   = 1;
    localparam int CTRL_ERR_CLR = 2;

    localparam int STAT_BUSY  = 0;
    localparam int STAT_DONE  = 1;
    localparam int STAT_ERROR = 2;

    function automatic logic idx_ok(idx_t v);
        return {1'b0, v} < (IDX_W+1)'(N_NODES);
    endfunction
endpackage

// File: rtl/graph_loader_if.sv
// Avalon-MM-style host slave bus into the graph loader.
interface graph_loader_if;
    import hft_pkg::*;

    logic                chipselect;
    logic                write;
    logic                read;
    logic [ADDR_W-1:0]   address;
    logic [WEIGHT_W-1:0] writedata;
    logic [WEIGHT_W-1:0] readdata;

    modport master (output chipselect, write, read, address, writedata, input readdata);
    modport slave  (input chipselect, write, read, address, writedata, output readdata);
endinterface

// File: rtl/graph_loader.sv
// Host write/control front end: owns the adjacency matrix and source vertex, launches container runs.
// Latency: readdata one cycle after a read; matrix/SRC writes visible on the next cycle.
// Backpressure: none; every access completes in one cycle, writes refused while busy raise error.
module graph_loader
    import hft_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    graph_loader_if.slave bus,
    output adjmat_t       adjmat,
    output idx_t          src,
    output logic          run_reset,
    input  logic          run_done
);
    typedef enum logic [1:0] {IDLE, CLEAR, LAUNCH, WAIT} state_t;

    state_t              state, state_next;
    idx_t                clear_row;
    logic                launch_cnt;
    logic                done, error;
    logic                mat_we, src_we, err_set, launch_go;
    logic [WEIGHT_W-1:0] rd_data;

    wire  is_ctrl  = bus.address[ADDR_W-1];
    idx_t acc_row;
    idx_t acc_col;
    assign acc_row = bus.address[2*IDX_W-1:IDX_W];
    assign acc_col = bus.address[IDX_W-1:0];
    wire [1:0] reg_off = bus.address[1:0];

    wire wr       = bus.chipselect & bus.write;
    wire rd       = bus.chipselect & bus.read;
    wire mat_wr   = wr & ~is_ctrl;
    wire ctrl_wr  = wr & is_ctrl & (reg_off == CTRL_OFF);
    wire src_wr   = wr & is_ctrl & (reg_off == SRC_OFF);
    wire do_start = bus.writedata[CTRL_START];
    wire do_clear = bus.writedata[CTRL_CLEAR];
    wire do_eclr  = bus.writedata[CTRL_ERR_CLR];
    wire busy     = (state != IDLE);
    wire pos_ok   = idx_ok(acc_row) & idx_ok(acc_col);
    wire src_ok   = bus.writedata < WEIGHT_W'(N_NODES);

    always_comb begin
        state_next = state;
        mat_we     = 1'b0;
        src_we     = 1'b0;
        err_set    = 1'b0;
        launch_go  = 1'b0;
        case (state)
            IDLE: begin
                mat_we  = mat_wr & pos_ok;
                src_we  = src_wr & src_ok;
                // CLEAR wins over START in the same write; the dropped START is an error.
                err_set = (mat_wr & ~pos_ok) | (src_wr & ~src_ok) | (ctrl_wr & do_start & do_clear);
                if (ctrl_wr & do_clear) begin
                    state_next = CLEAR;
                end else if (ctrl_wr & do_start) begin
                    state_next = LAUNCH;
                    launch_go  = 1'b1;
                end
            end
            CLEAR:  if (clear_row == idx_t'(N_NODES-1)) state_next = IDLE;
            LAUNCH: if (launch_cnt) state_next = WAIT;
            WAIT:   if (run_done) state_next = IDLE;
            default: state_next = CLEAR;
        endcase
        if (busy) begin
            err_set = mat_wr | src_wr | (ctrl_wr & (do_start | do_clear));
        end
    end

    always_comb begin
        rd_data = '0;
        if (!is_ctrl) begin
            if (pos_ok) rd_data = adjmat[acc_row][acc_col];
        end else begin
            case (reg_off)
                SRC_OFF: rd_data = WEIGHT_W'(src);
                STATUS_OFF: begin
                    rd_data[STAT_BUSY]  = busy;
                    rd_data[STAT_DONE]  = done;
                    rd_data[STAT_ERROR] = error;
                end
                default: rd_data = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= CLEAR;
            clear_row    <= '0;
            launch_cnt   <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            src          <= '0;
            run_reset    <= 1'b0;
            bus.readdata <= '0;
        end else begin
            state      <= state_next;
            clear_row  <= (state == CLEAR && clear_row != idx_t'(N_NODES-1)) ? clear_row + 1'b1 : '0;
            launch_cnt <= (state == LAUNCH) ? ~launch_cnt : 1'b0;
            // Held through both LAUNCH cycles so the container's registered done clear is covered.
            run_reset  <= (state_next == LAUNCH);
            if (launch_go) begin
                done <= 1'b0;
            end else if (state == WAIT && run_done) begin
                done <= 1'b1;
            end
            if (err_set) begin
                error <= 1'b1;
            end else if (ctrl_wr && do_eclr) begin
                error <= 1'b0;
            end
            if (src_we) src <= bus.writedata[IDX_W-1:0];
            if (rd) bus.readdata <= rd_data;
        end
    end

    // Matrix has no reset of its own; the CLEAR sweep initialises it one row per cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (state == CLEAR) begin
                for (int c = 0; c < N_NODES; c++) begin
                    adjmat[clear_row][c] <= (c == int'(clear_row)) ? weight_t'(0) : INF;
                end
            end else if (mat_we) begin
                adjmat[acc_row][acc_col] <= bus.writedata;
            end
        end
    end
endmodule

// File: tb/tb_graph_loader.sv
// Directed bench for graph_loader: vector table for IDLE register access plus launch/busy/reset sequences.
module tb_graph_loader;
    import hft_pkg::*;

    logic    clk;
    logic    reset;
    logic    run_done;
    logic    run_reset;
    idx_t    src;
    adjmat_t adjmat;

    graph_loader_if bus();

    graph_loader dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .adjmat    (adjmat),
        .src       (src),
        .run_reset (run_reset),
        .run_done  (run_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic                is_read;
        logic [ADDR_W-1:0]   addr;
        logic [WEIGHT_W-1:0] data;
        string               name;
    } vec_t;

    vec_t vecs[15];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [31:0] u(input weight_t w);
        return {16'h0, w};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [ADDR_W-1:0] a, input logic [WEIGHT_W-1:0] d);
        bus.chipselect = 1'b1;
        bus.write      = 1'b1;
        bus.address    = a;
        bus.writedata  = d;
        tick();
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
    endtask

    task automatic bus_read(input logic [ADDR_W-1:0] a, output logic [WEIGHT_W-1:0] d);
        bus.chipselect = 1'b1;
        bus.read       = 1'b1;
        bus.address    = a;
        tick();
        d = bus.readdata;
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
    endtask

    task automatic poll_status(input int cycles, output int n_busy, output int n_rr);
        n_busy = 0;
        n_rr   = 0;
        bus.chipselect = 1'b1;
        bus.read       = 1'b1;
        bus.address    = 9'h102;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (bus.readdata[STAT_BUSY]) n_busy++;
            if (run_reset) n_rr++;
        end
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
    endtask

    initial begin
        logic [WEIGHT_W-1:0] rd;
        int nb, nr;

        vecs[0]  = '{1'b1, 9'h102, 16'h0000, "status_idle"};
        vecs[1]  = '{1'b1, 9'h033, 16'h0000, "diag_3_3"};
        vecs[2]  = '{1'b1, 9'h034, 16'h7FFF, "inf_3_4"};
        vecs[3]  = '{1'b0, 9'h025, 16'hFF88, "wr_2_5"};
        vecs[4]  = '{1'b1, 9'h025, 16'hFF88, "rd_2_5"};
        vecs[5]  = '{1'b0, 9'h0F0, 16'h0123, "wr_15_0"};
        vecs[6]  = '{1'b1, 9'h0F0, 16'h0123, "rd_15_0"};
        vecs[7]  = '{1'b0, 9'h101, 16'h0007, "wr_src7"};
        vecs[8]  = '{1'b1, 9'h101, 16'h0007, "rd_src7"};
        vecs[9]  = '{1'b0, 9'h101, 16'h0014, "wr_src20"};
        vecs[10] = '{1'b1, 9'h101, 16'h0007, "src_kept"};
        vecs[11] = '{1'b1, 9'h102, 16'h0004, "status_err"};
        vecs[12] = '{1'b0, 9'h100, 16'h0004, "wr_errclr"};
        vecs[13] = '{1'b1, 9'h102, 16'h0000, "status_errclr"};
        vecs[14] = '{1'b1, 9'h103, 16'h0000, "reg3_zero"};

        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
        bus.read       = 1'b0;
        bus.address    = '0;
        bus.writedata  = '0;
        run_done       = 1'b0;
        reset          = 1'b0;
        repeat (3) tick();
        check("rst_readdata", 32'(bus.readdata), 32'h0);
        check("rst_run_reset", 32'(run_reset), 32'h0);
        check("rst_src", 32'(src), 32'h0);

        reset = 1'b1;
        poll_status(24, nb, nr);
        check("clear_busy_cycles", 32'(nb), 32'd16);
        check("clear_no_run_reset", 32'(nr), 32'd0);
        check("port_diag_3_3", u(adjmat[3][3]), 32'h0);
        check("port_inf_3_4", u(adjmat[3][4]), 32'h7FFF);

        for (int i = 0; i < 15; i++) begin
            if (vecs[i].is_read) begin
                bus_read(vecs[i].addr, rd);
                check(vecs[i].name, 32'(rd), 32'(vecs[i].data));
            end else begin
                bus_write(vecs[i].addr, vecs[i].data);
            end
        end
        check("port_2_5", u(adjmat[2][5]), 32'hFF88);

        // Read and write of the same entry in one cycle returns the old value.
        bus.chipselect = 1'b1;
        bus.write      = 1'b1;
        bus.read       = 1'b1;
        bus.address    = 9'h025;
        bus.writedata  = 16'h0042;
        tick();
        check("rw_same_old", 32'(bus.readdata), 32'hFF88);
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
        bus.read       = 1'b0;
        bus_read(9'h025, rd);
        check("rw_same_new", 32'(rd), 32'h0042);

        // Launch with a stale run_done held through LAUNCH.
        run_done = 1'b1;
        bus_write(9'h100, 16'h0001);
        check("launch_rr_c1", 32'(run_reset), 32'h1);
        bus_read(9'h102, rd);
        check("launch_status", 32'(rd), 32'h1);
        check("launch_rr_c2", 32'(run_reset), 32'h1);
        run_done = 1'b0;
        tick();
        check("launch_rr_c3", 32'(run_reset), 32'h0);
        check("launch_src", 32'(src), 32'h7);
        bus_read(9'h102, rd);
        check("wait_status", 32'(rd), 32'h1);
        repeat (3) tick();
        run_done = 1'b1;
        tick();
        bus_read(9'h102, rd);
        check("done_status", 32'(rd), 32'h2);

        // Second run: writes while busy are refused.
        run_done = 1'b0;
        bus_write(9'h100, 16'h0001);
        repeat (2) tick();
        bus_read(9'h102, rd);
        check("wait2_done_cleared", 32'(rd), 32'h1);
        bus_write(9'h011, 16'h0009);
        bus_write(9'h100, 16'h0001);
        check("busy_start_rr", 32'(run_reset), 32'h0);
        tick();
        check("busy_start_rr2", 32'(run_reset), 32'h0);
        check("busy_mat_kept", u(adjmat[1][1]), 32'h0);
        bus_read(9'h102, rd);
        check("busy_err_status", 32'(rd), 32'h5);
        bus_write(9'h100, 16'h0004);
        bus_read(9'h102, rd);
        check("busy_errclr", 32'(rd), 32'h1);

        // Reset mid-run: CLEAR restarts at row 0.
        reset = 1'b0;
        tick();
        check("midrst_run_reset", 32'(run_reset), 32'h0);
        check("midrst_readdata", 32'(bus.readdata), 32'h0);
        reset = 1'b1;
        repeat (3) tick();
        check("midrst_row2_cleared", u(adjmat[2][5]), 32'h7FFF);
        check("midrst_row15_pending", u(adjmat[15][0]), 32'h0123);
        run_done = 1'b1;
        poll_status(20, nb, nr);
        check("midrst_late_done", 32'(bus.readdata), 32'h0);
        check("midrst_no_run_reset", 32'(nr), 32'd0);
        check("midrst_row15_cleared", u(adjmat[15][0]), 32'h7FFF);
        run_done = 1'b0;

        // CLEAR|START in IDLE: full sweep, no launch, error raised.
        bus_write(9'h046, 16'h0005);
        check("port_4_6", u(adjmat[4][6]), 32'h5);
        bus_write(9'h100, 16'h0003);
        poll_status(24, nb, nr);
        check("clr_start_busy", 32'(nb), 32'd16);
        check("clr_start_no_rr", 32'(nr), 32'd0);
        check("clr_start_status", 32'(bus.readdata), 32'h4);
        check("clr_start_4_6", u(adjmat[4][6]), 32'h7FFF);
        check("clr_start_diag", u(adjmat[4][4]), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
